// File: rtl/efpga_frame_loader.sv
// efpga_frame_loader
//   Streams a 32-bit bitstream (valid/ready) into the eFPGA configuration
//   interface.  After SYNC_WORD, every header word selects a column/frame.
//   The next NUM_ROWS+2 words fill FrameData.  The loader then pulses the
//   matching one-hot FrameStrobe bit for STROBE_CYCLES cycles.
//   A header with DESYNC_BIT set ends the session.
//
//   Optional feature macro: CFG_CHECKSUM_EN
//     When defined, the loader keeps an additive 32-bit sum of all data words
//     since SYNC_WORD.  The word that follows the desync header is compared
//     against that sum.
//
// Ports
//   CLK           config clock
//   reset         asynchronous, active-high reset
//   s_data        bitstream word
//   s_valid       s_data valid
//   s_ready       word accepted this cycle when s_valid is also high
//   frame_data    assembled FrameData, word 0 = bottom terminal row
//   frame_strobe  one-hot (or zero) FrameStrobe, bit = col*MAX_FRAMES_PER_COL+frame
//   synced        session active
//   addr_err      sticky: a header addressed a column/frame out of range
//   crc_err       sticky: checksum mismatch (0 without CFG_CHECKSUM_EN)
//   frames_done   frames strobed since reset, wraps at 2^16
//
// States
//   S_IDLE   | waiting for SYNC_WORD, other words dropped
//   S_HEADER | expecting a header (column/frame or desync)
//   S_DATA   | collecting NUM_ROWS+2 data words
//   S_STROBE | FrameStrobe high, input stalled
//   S_CHECK  | expecting the checksum word (CFG_CHECKSUM_EN only)

module efpga_frame_loader #(
  parameter int          NUM_ROWS           = 3,
  parameter int          NUM_COLS           = 5,
  parameter int          FRAME_BITS_PER_ROW = 32,
  parameter int          MAX_FRAMES_PER_COL = 36,
  parameter int          DESYNC_BIT         = 20,
  parameter int          STROBE_CYCLES      = 1,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1
) (
  input  logic                                        CLK,
  input  logic                                        reset,
  input  logic [31:0]                                 s_data,
  input  logic                                        s_valid,
  output logic                                        s_ready,
  output logic [FRAME_BITS_PER_ROW*(NUM_ROWS+2)-1:0]  frame_data,
  output logic [NUM_COLS*MAX_FRAMES_PER_COL-1:0]      frame_strobe,
  output logic                                        synced,
  output logic                                        addr_err,
  output logic                                        crc_err,
  output logic [15:0]                                 frames_done
);

  localparam int NWORDS = NUM_ROWS + 2;
  localparam int WB     = FRAME_BITS_PER_ROW;
  localparam int SW     = NUM_COLS * MAX_FRAMES_PER_COL;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);
  localparam logic [7:0]      COL_LIM  = 8'(NUM_COLS);
  localparam logic [7:0]      FRM_LIM  = 8'(MAX_FRAMES_PER_COL);
  localparam logic [3:0]      STB_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [SW-1:0]   STB_ONE  = SW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_STROBE,
    S_CHECK
  } state_t;

  state_t             r_state;
  logic [7:0]         r_col;
  logic [7:0]         r_frame;
  logic               r_in_range;
  logic [IDXW-1:0]    r_idx;
  logic [3:0]         r_stb_cnt;
  logic               r_s_ready;
  logic [WB*NWORDS-1:0] r_frame_data;
  logic [SW-1:0]      r_frame_strobe;
  logic               r_synced;
  logic               r_addr_err;
  logic [15:0]        r_frames_done;

  logic               w_xfer;
  logic               w_hdr_ok;
  logic [15:0]        w_lin;

  assign w_xfer   = s_valid & r_s_ready;
  assign w_hdr_ok = (s_data[15:8] < COL_LIM) && (s_data[7:0] < FRM_LIM);
  // Linear strobe index; only used when the latched header was in range.
  assign w_lin    = 16'(r_col) * 16'(MAX_FRAMES_PER_COL) + 16'(r_frame);

`ifdef CFG_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        r_crc_err;
  assign crc_err = r_crc_err;
`else
  assign crc_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_col          <= '0;
      r_frame        <= '0;
      r_in_range     <= 1'b0;
      r_idx          <= '0;
      r_stb_cnt      <= '0;
      r_s_ready      <= 1'b1;
      r_frame_data   <= '0;
      r_frame_strobe <= '0;
      r_synced       <= 1'b0;
      r_addr_err     <= 1'b0;
      r_frames_done  <= '0;
`ifdef CFG_CHECKSUM_EN
      r_sum          <= '0;
      r_crc_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer && (s_data == SYNC_WORD)) begin
            r_state  <= S_HEADER;
            r_synced <= 1'b1;
`ifdef CFG_CHECKSUM_EN
            r_sum    <= '0;
`endif
          end
        end

        S_HEADER: begin
          if (w_xfer) begin
            if (s_data[DESYNC_BIT]) begin
`ifdef CFG_CHECKSUM_EN
              // synced stays high until the checksum word is consumed
              r_state  <= S_CHECK;
`else
              r_state  <= S_IDLE;
              r_synced <= 1'b0;
`endif
            end else begin
              r_col      <= s_data[15:8];
              r_frame    <= s_data[7:0];
              r_in_range <= w_hdr_ok;
              r_idx      <= '0;
              if (!w_hdr_ok) r_addr_err <= 1'b1;
              r_state    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            // Out-of-range frames still load frame_data; they simply never strobe.
            for (int k = 0; k < NWORDS; k++) begin
              if (r_idx == IDXW'(k)) r_frame_data[WB*k +: WB] <= s_data;
            end
`ifdef CFG_CHECKSUM_EN
            r_sum <= r_sum + s_data;
`endif
            if (r_idx == LAST_IDX) begin
              if (r_in_range) begin
                r_frame_strobe <= STB_ONE << w_lin;
                r_stb_cnt      <= STB_LOAD;
                r_s_ready      <= 1'b0;
                r_state        <= S_STROBE;
              end else begin
                r_state        <= S_HEADER;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        S_STROBE: begin
          if (r_stb_cnt == 4'd0) begin
            r_frame_strobe <= '0;
            r_frames_done  <= r_frames_done + 16'd1;
            r_s_ready      <= 1'b1;
            r_state        <= S_HEADER;
          end else begin
            r_stb_cnt <= r_stb_cnt - 4'd1;
          end
        end

`ifdef CFG_CHECKSUM_EN
        S_CHECK: begin
          if (w_xfer) begin
            if (s_data != r_sum) r_crc_err <= 1'b1;
            r_synced <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
`endif

        default: begin
          r_state        <= S_IDLE;
          r_synced       <= 1'b0;
          r_s_ready      <= 1'b1;
          r_frame_strobe <= '0;
        end
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign frame_data   = r_frame_data;
  assign frame_strobe = r_frame_strobe;
  assign synced       = r_synced;
  assign addr_err     = r_addr_err;
  assign frames_done  = r_frames_done;

endmodule
